// File: rtl/tlb_search_arbiter_pkg.sv
// Shared constants for the TLB search-port arbiter: response word layout,
// requester indices, default starvation limit and the response slot state.
package tlb_search_arbiter_pkg;

    // Response word width at the default TLBNUM=16 (IDXW=4).
    localparam int TLB_RESP_W = 37;
    localparam int NUM_REQ    = 3;

    // Requester indices: CSR tlbsrch, MEM-stage translation, IF-stage fetch.
    localparam int REQ_SRCH  = 0;
    localparam int REQ_MEM   = 1;
    localparam int REQ_FETCH = 2;

    // Bit offsets inside one response word {found, index, ppn, ps, plv, mat, d, v}.
    // INDEX/FOUND offsets are given for IDXW=4.
    localparam int RESP_V_OFS     = 0;
    localparam int RESP_D_OFS     = 1;
    localparam int RESP_MAT_OFS   = 2;
    localparam int RESP_PLV_OFS   = 4;
    localparam int RESP_PS_OFS    = 6;
    localparam int RESP_PPN_OFS   = 12;
    localparam int RESP_INDEX_OFS = 32;
    localparam int RESP_FOUND_OFS = 36;

    localparam int STARVE_LIMIT_DEF = 3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/tlb_resp_slot.sv
// One per-requester response holding register. It is EMPTY or FULL; a load
// captures the search result, a consume empties it, a clear (flush) empties it
// regardless. Load beats consume so consume + reload in one cycle stays FULL.
module tlb_resp_slot
    import tlb_search_arbiter_pkg::*;
#(
    parameter int W = TLB_RESP_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_consume,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    slot_state_e r_state;
    logic [W-1:0] r_data;

    // Slot state and captured data; data is only written on a load so it holds while FULL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
        end else if (i_clear) begin
            r_state <= SLOT_EMPTY;
        end else if (i_load) begin
            r_state <= SLOT_FULL;
            r_data  <= i_data;
        end else if (i_consume) begin
            r_state <= SLOT_EMPTY;
        end
    end

    assign o_valid = (r_state == SLOT_FULL);
    assign o_data  = r_data;

endmodule

// File: rtl/tlb_search_arbiter.sv
// Arbiter sharing the single TLB search port between CSR tlbsrch (R0),
// MEM-stage translation (R1) and IF-stage fetch translation (R2).
// Fixed priority R0 > R1 > R2, with R2 promoted above R1 for one grant after
// STARVE_LIMIT consecutive denied cycles. Optional perf counters are built
// when TLB_ARB_PERF_EN is defined.
//
// Handshake: a request i is taken when req_valid[i] & req_ready[i]; the search
// happens combinationally in that cycle and resp_valid[i] rises on the next
// cycle. A result is consumed when resp_valid[i] & resp_ready[i]; the slot
// holds its data until then. req_ready may depend on resp_ready, resp_valid
// never does.
module tlb_search_arbiter
    import tlb_search_arbiter_pkg::*;
#(
    parameter  int TLBNUM       = 16,
    parameter  int STARVE_LIMIT = STARVE_LIMIT_DEF,
    localparam int IDXW         = $clog2(TLBNUM),
    localparam int RW           = 33 + IDXW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      req_valid,
    output logic [2:0]      req_ready,
    input  logic [3*19-1:0] req_vppn,
    input  logic [2:0]      req_va_bit12,
    input  logic [9:0]      csr_asid,
    input  logic            flush,
    input  logic            tlb_busy,
    output logic [18:0]     s_vppn,
    output logic            s_va_bit12,
    output logic [9:0]      s_asid,
    input  logic            s_found,
    input  logic [IDXW-1:0] s_index,
    input  logic [19:0]     s_ppn,
    input  logic [5:0]      s_ps,
    input  logic [1:0]      s_plv,
    input  logic [1:0]      s_mat,
    input  logic            s_d,
    input  logic            s_v,
    output logic [2:0]      resp_valid,
    input  logic [2:0]      resp_ready,
    output logic [3*RW-1:0] resp_data
`ifdef TLB_ARB_PERF_EN
    ,
    output logic [31:0]     perf_conflict,
    output logic [31:0]     perf_starve_promote
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [2:0]    w_slot_free;
    logic [2:0]    w_elig;
    logic [2:0]    w_grant;
    logic [2:0]    w_consume;
    logic [2:0]    w_clear;
    logic          w_promote;
    logic [RW-1:0] w_result;
    logic [3:0]    r_starve_cnt;

    // A slot can accept a new result if empty or being drained this cycle.
    assign w_slot_free = ~resp_valid | resp_ready;
    assign w_elig[0]   = req_valid[0] & w_slot_free[0] & ~tlb_busy;
    assign w_elig[2:1] = req_valid[2:1] & w_slot_free[2:1] & {2{~tlb_busy & ~flush}};
    assign w_promote   = (r_starve_cnt == LIMIT);

    // One-hot grant: R0 always first; a starved R2 jumps ahead of R1.
    always_comb begin
        w_grant = 3'b000;
        if (w_elig[REQ_SRCH])                    w_grant = 3'b001;
        else if (w_promote && w_elig[REQ_FETCH]) w_grant = 3'b100;
        else if (w_elig[REQ_MEM])                w_grant = 3'b010;
        else if (w_elig[REQ_FETCH])              w_grant = 3'b100;
    end

    assign req_ready = w_grant;

    // Search address mux; idles on R2's inputs and forces zero during reset.
    always_comb begin
        s_vppn     = req_vppn[REQ_FETCH*19 +: 19];
        s_va_bit12 = req_va_bit12[REQ_FETCH];
        if (w_grant[REQ_SRCH]) begin
            s_vppn     = req_vppn[REQ_SRCH*19 +: 19];
            s_va_bit12 = req_va_bit12[REQ_SRCH];
        end else if (w_grant[REQ_MEM]) begin
            s_vppn     = req_vppn[REQ_MEM*19 +: 19];
            s_va_bit12 = req_va_bit12[REQ_MEM];
        end
        if (reset) begin
            s_vppn     = '0;
            s_va_bit12 = 1'b0;
        end
    end

    assign s_asid    = csr_asid;
    assign w_result  = {s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v};
    assign w_consume = resp_valid & resp_ready;
    assign w_clear   = {flush, flush, 1'b0};

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
        tlb_resp_slot #(.W(RW)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .i_load    (w_grant[gi]),
            .i_consume (w_consume[gi]),
            .i_clear   (w_clear[gi]),
            .i_data    (w_result),
            .o_valid   (resp_valid[gi]),
            .o_data    (resp_data[gi*RW +: RW])
        );
    end

    // Fetch starvation counter: counts denied, non-busy request cycles and saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (flush || !req_valid[REQ_FETCH] || w_grant[REQ_FETCH]) begin
            r_starve_cnt <= 4'd0;
        end else if (!tlb_busy && !w_promote) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

`ifdef TLB_ARB_PERF_EN
    logic w_conflict;
    logic w_promo_grant;

    assign w_conflict    = (w_elig[0] & w_elig[1]) | (w_elig[0] & w_elig[2]) | (w_elig[1] & w_elig[2]);
    assign w_promo_grant = w_grant[REQ_FETCH] & w_promote & w_elig[REQ_MEM];

    // Wrapping event counters for contention and promotion-driven fetch grants.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_conflict       <= 32'd0;
            perf_starve_promote <= 32'd0;
        end else begin
            if (w_conflict)    perf_conflict       <= perf_conflict + 32'd1;
            if (w_promo_grant) perf_starve_promote <= perf_starve_promote + 32'd1;
        end
    end
`endif

endmodule
